// File: rtl/display_scan_ctrl.sv
// Two-digit multiplexed 7-segment scan driver with frame-aligned shadow loading.
// Optional dead-time blanking between digits is enabled by defining SCAN_BLANK_EN.
module display_scan_ctrl #(
    parameter int CLK_HZ    = 50000000,
    parameter int SCAN_HZ   = 64,
    parameter int BLANK_CYC = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] t_val,
    input  logic [3:0] v_val,
    input  logic       load,
    output logic [6:0] Tseg,
    output logic [6:0] Vseg,
    output logic       clk_aux,
    output logic       an_t,
    output logic       an_v,
    output logic       frame,
    output logic       pend
);

    localparam int HALF_CYC = CLK_HZ / (2 * SCAN_HZ);
    localparam int CW       = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;

    if (BLANK_CYC >= HALF_CYC) begin : g_bad_blank
        $error("BLANK_CYC must be smaller than HALF_CYC");
    end

    typedef enum logic [1:0] {
        BLANK_VT = 2'd0,
        SHOW_T   = 2'd1,
        BLANK_TV = 2'd2,
        SHOW_V   = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] phase;
    logic [3:0]    pend_t;
    logic [3:0]    pend_v;
    logic          wrap;
    logic          commit_edge;

    assign wrap = (phase == CW'(HALF_CYC - 1));

`ifdef SCAN_BLANK_EN
    logic show_start;
    assign show_start = (phase == CW'(BLANK_CYC - 1));
`endif

    // The edge that enters SHOW_T: frame pulse and shadow-to-display commit.
    always_comb begin
        commit_edge = 1'b0;
`ifdef SCAN_BLANK_EN
        if (state == BLANK_VT && show_start) commit_edge = 1'b1;
`else
        if (state == SHOW_V && wrap) commit_edge = 1'b1;
`endif
    end

    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef SCAN_BLANK_EN
            state <= BLANK_VT;
            an_t  <= 1'b1;
`else
            state <= SHOW_T;
            an_t  <= 1'b0;
`endif
            phase   <= '0;
            clk_aux <= 1'b1;
            an_v    <= 1'b1;
            frame   <= 1'b0;
            pend    <= 1'b0;
            pend_t  <= '0;
            pend_v  <= '0;
            Tseg    <= 7'h40;
            Vseg    <= 7'h40;
        end else begin
            phase <= wrap ? '0 : phase + CW'(1);
            frame <= commit_edge;

`ifdef SCAN_BLANK_EN
            case (state)
                BLANK_VT: if (show_start) begin
                    state <= SHOW_T;
                    an_t  <= 1'b0;
                end
                SHOW_T: if (wrap) begin
                    state   <= BLANK_TV;
                    an_t    <= 1'b1;
                    clk_aux <= 1'b0;
                end
                BLANK_TV: if (show_start) begin
                    state <= SHOW_V;
                    an_v  <= 1'b0;
                end
                default: if (wrap) begin
                    state   <= BLANK_VT;
                    an_v    <= 1'b1;
                    clk_aux <= 1'b1;
                end
            endcase
`else
            case (state)
                SHOW_T: if (wrap) begin
                    state   <= SHOW_V;
                    an_t    <= 1'b1;
                    an_v    <= 1'b0;
                    clk_aux <= 1'b0;
                end
                SHOW_V: if (wrap) begin
                    state   <= SHOW_T;
                    an_v    <= 1'b1;
                    an_t    <= 1'b0;
                    clk_aux <= 1'b1;
                end
                default: begin
                    state   <= SHOW_T;
                    an_t    <= 1'b0;
                    an_v    <= 1'b1;
                    clk_aux <= 1'b1;
                end
            endcase
`endif

            // A load on the commit edge is captured after the old pair commits,
            // so its pend assignment below must win over the clear.
            if (commit_edge && pend) begin
                Tseg <= seg_enc(pend_t);
                Vseg <= seg_enc(pend_v);
                pend <= 1'b0;
            end
            if (load) begin
                pend_t <= t_val;
                pend_v <= v_val;
                pend   <= 1'b1;
            end
        end
    end

endmodule
